// File: rtl/apb_pkg.sv
// Shared types and constants for the APB master controller.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } apb_state_t;

  localparam logic [1:0] SEL_NONE  = 2'b00;
  localparam logic [1:0] SEL_S0    = 2'b01;
  localparam logic [1:0] SEL_S1    = 2'b10;
  localparam logic [7:0] RDATA_ERR = 8'hFF;

  function automatic logic sel_legal(input logic [1:0] sel);
    return (sel == SEL_S0) || (sel == SEL_S1);
  endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase timeout counter: counts ready-low cycles, flags the cycle whose
// increment reaches the limit so the FSM can abort on that same edge.
module apb_timeout_cnt (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic [8:0] limit,
  output logic       expire
);

  logic [8:0] cnt;

  assign expire = en && ((cnt + 9'd1) == limit);

  always_ff @(posedge clk) begin
    if (reset || clr) cnt <= '0;
    else if (en)      cnt <= cnt + 9'd1;
  end

endmodule

// File: rtl/apb_master_ctrl.sv
// APB master: one processor request at a time, SETUP then ACCESS, with a
// bounded wait on the slave's ready and a one-cycle completion strobe.
module apb_master_ctrl
  import apb_pkg::*;
#(
  parameter int TIMEOUT_MARGIN = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       proc_start,
  input  logic       proc_write,
  input  logic [1:0] proc_sel,
  input  logic [7:0] proc_addr,
  input  logic [7:0] proc_wdata,
  input  logic [7:0] proc_wait_cycles,
  output logic [7:0] proc_rdata,
  output logic       proc_stable,
  output logic       proc_err,
  output logic [1:0] apb_sel,
  output logic       apb_enable,
  output logic       apb_write,
  output logic [7:0] apb_addr,
  output logic [7:0] apb_wdata,
  output logic [7:0] apb_wait_cycles,
  input  logic       apb_ready,
  input  logic [7:0] apb_rdata
);

  apb_state_t state;
  logic       cnt_clr, cnt_en, expire;
  logic [8:0] limit;

  // The APB output registers double as the capture registers for the request.
  assign limit   = {1'b0, apb_wait_cycles} + 9'(TIMEOUT_MARGIN);
  assign cnt_clr = (state == IDLE) && proc_start && sel_legal(proc_sel);
  assign cnt_en  = (state == ACCESS) && !apb_ready;

  apb_timeout_cnt u_tmo (
    .clk    (clk),
    .reset  (reset),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .limit  (limit),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      proc_rdata      <= '0;
      proc_stable     <= 1'b0;
      proc_err        <= 1'b0;
      apb_sel         <= SEL_NONE;
      apb_enable      <= 1'b0;
      apb_write       <= 1'b0;
      apb_addr        <= '0;
      apb_wdata       <= '0;
      apb_wait_cycles <= '0;
    end else begin
      case (state)
        IDLE: begin
          proc_stable <= 1'b0;
          if (proc_start) begin
            if (sel_legal(proc_sel)) begin
              apb_sel         <= proc_sel;
              apb_enable      <= 1'b0;
              apb_write       <= proc_write;
              apb_addr        <= proc_addr;
              apb_wdata       <= proc_wdata;
              apb_wait_cycles <= proc_wait_cycles;
              state           <= SETUP;
            end else begin
              proc_stable <= 1'b1;
              proc_err    <= 1'b1;
              state       <= DONE;
            end
          end
        end
        SETUP: begin
          apb_enable <= 1'b1;
          state      <= ACCESS;
        end
        ACCESS: begin
          // Ready wins over a timeout landing on the same edge.
          if (apb_ready || expire) begin
            if (!apb_write) proc_rdata <= apb_ready ? apb_rdata : RDATA_ERR;
            proc_err    <= !apb_ready;
            proc_stable <= 1'b1;
            apb_sel     <= SEL_NONE;
            apb_enable  <= 1'b0;
            state       <= DONE;
          end
        end
        DONE: begin
          proc_stable <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Randomized bench for apb_master_ctrl with a transaction-level expected model.
module tb_apb_master_ctrl;

  localparam int M = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       proc_start, proc_write;
  logic [1:0] proc_sel;
  logic [7:0] proc_addr, proc_wdata, proc_wait_cycles;
  logic [7:0] proc_rdata;
  logic       proc_stable, proc_err;
  logic [1:0] apb_sel;
  logic       apb_enable, apb_write;
  logic [7:0] apb_addr, apb_wdata, apb_wait_cycles;
  logic       apb_ready;
  logic [7:0] apb_rdata;

  int checks = 0;
  int failures = 0;
  logic [7:0] rd_model;

  apb_master_ctrl #(.TIMEOUT_MARGIN(M)) dut (
    .clk(clk), .reset(reset),
    .proc_start(proc_start), .proc_write(proc_write), .proc_sel(proc_sel),
    .proc_addr(proc_addr), .proc_wdata(proc_wdata), .proc_wait_cycles(proc_wait_cycles),
    .proc_rdata(proc_rdata), .proc_stable(proc_stable), .proc_err(proc_err),
    .apb_sel(apb_sel), .apb_enable(apb_enable), .apb_write(apb_write),
    .apb_addr(apb_addr), .apb_wdata(apb_wdata), .apb_wait_cycles(apb_wait_cycles),
    .apb_ready(apb_ready), .apb_rdata(apb_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // k = ready-low ACCESS cycles before ready rises; k >= limit means no ready.
  task automatic run_txn(input logic w, input logic [1:0] sel, input logic [7:0] addr,
                         input logic [7:0] wdata, input logic [7:0] wt, input int k,
                         input logic [7:0] sd, input logic busy, input logic rdy_setup);
    int   lim, exp_c, pulses, first;
    logic legal, eerr;
    legal = (sel == 2'b01) || (sel == 2'b10);
    lim   = int'(wt) + M;
    if (!legal) begin
      exp_c = 1; eerr = 1'b1;
    end else if (k < lim) begin
      exp_c = 3 + k; eerr = 1'b0;
      if (!w) rd_model = sd;
    end else begin
      exp_c = 2 + lim; eerr = 1'b1;
      if (!w) rd_model = 8'hFF;
    end
    @(negedge clk);
    proc_start = 1'b1; proc_write = w; proc_sel = sel; proc_addr = addr;
    proc_wdata = wdata; proc_wait_cycles = wt; apb_ready = 1'b0;
    pulses = 0; first = -1;
    for (int c = 1; c <= exp_c + 1; c++) begin
      @(negedge clk);
      proc_start = busy && (c == 2);
      proc_sel   = busy ? 2'b01 : proc_sel;
      apb_ready  = legal && ((c == 1) ? rdy_setup : (c - 2 == k));
      apb_rdata  = (c - 2 == k) ? sd : 8'($urandom);
      if (c == 1 && legal)
        check("setup_bus", 64'({apb_sel, apb_enable, apb_write, apb_addr, apb_wdata, apb_wait_cycles}),
              64'({sel, 1'b0, w, addr, wdata, wt}));
      if (c == 1 && !legal)
        check("illegal_bus_idle", 64'({apb_sel, apb_enable}), 64'(0));
      if (c == 2 && legal)
        check("access_bus", 64'({apb_sel, apb_enable}), 64'({sel, 1'b1}));
      if (proc_stable) begin
        pulses++;
        if (first < 0) begin
          first = c;
          check("done_err", 64'(proc_err), 64'(eerr));
          check("done_rdata", 64'(proc_rdata), 64'(rd_model));
          check("done_bus", 64'({apb_sel, apb_enable}), 64'(0));
        end
      end
    end
    apb_ready = 1'b0; proc_start = 1'b0;
    check("strobe_count", 64'(pulses), 64'(1));
    check("strobe_cycle", 64'(first), 64'(exp_c));
  endtask

  initial begin
    int nstb;
    reset = 1'b1; proc_start = 1'b0; proc_write = 1'b0; proc_sel = 2'b00;
    proc_addr = '0; proc_wdata = '0; proc_wait_cycles = '0;
    apb_ready = 1'b0; apb_rdata = '0; rd_model = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", 64'({apb_sel, apb_enable, apb_write, apb_addr, apb_wdata, apb_wait_cycles,
                             proc_rdata, proc_stable, proc_err}), 64'(0));
    reset = 1'b0;

    run_txn(1'b1, 2'b01, 8'h10, 8'hA5, 8'd0, 0,    8'h77, 1'b0, 1'b0); // write, zero wait
    run_txn(1'b0, 2'b10, 8'h22, 8'h00, 8'd3, 3,    8'h5C, 1'b0, 1'b0); // read, 3 waits
    run_txn(1'b0, 2'b01, 8'h30, 8'h00, 8'd2, 1000, 8'h00, 1'b0, 1'b0); // timeout
    run_txn(1'b0, 2'b11, 8'h40, 8'h00, 8'd0, 0,    8'h00, 1'b0, 1'b0); // illegal sel
    run_txn(1'b0, 2'b00, 8'h41, 8'h00, 8'd0, 0,    8'h00, 1'b0, 1'b0); // no sel
    run_txn(1'b0, 2'b01, 8'h50, 8'h00, 8'd0, M-1,  8'h3A, 1'b0, 1'b1); // ready on last legal cycle
    run_txn(1'b0, 2'b10, 8'h51, 8'h00, 8'd0, M,    8'h3B, 1'b0, 1'b0); // ready one cycle too late
    run_txn(1'b0, 2'b10, 8'h60, 8'h00, 8'd1, 2,    8'hC3, 1'b1, 1'b1); // start during ACCESS ignored

    // Reset during ACCESS: outputs clear, no strobe, next request works.
    @(negedge clk);
    proc_start = 1'b1; proc_write = 1'b0; proc_sel = 2'b01; proc_addr = 8'h70;
    proc_wdata = 8'h11; proc_wait_cycles = 8'd5;
    @(negedge clk); proc_start = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    check("reset_mid", 64'({apb_sel, apb_enable, apb_write, apb_addr, apb_wdata, apb_wait_cycles,
                           proc_rdata, proc_stable, proc_err}), 64'(0));
    reset = 1'b0; rd_model = 8'h00;
    nstb = 0;
    repeat (4) begin
      @(negedge clk);
      if (proc_stable) nstb++;
    end
    check("no_strobe_after_reset", 64'(nstb), 64'(0));
    run_txn(1'b0, 2'b01, 8'h71, 8'h00, 8'd0, 1, 8'h3C, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      int r, kk, lim;
      logic [1:0] s;
      logic       w;
      logic [7:0] wt;
      r  = int'($urandom_range(0, 9));
      s  = (r == 0) ? 2'b11 : (r == 1) ? 2'b00 : (r < 6) ? 2'b01 : 2'b10;
      w  = 1'($urandom_range(0, 1));
      wt = 8'($urandom_range(0, 6));
      lim = int'(wt) + M;
      if (!w && $urandom_range(0, 3) == 0) kk = 1000;
      else kk = int'($urandom_range(0, 32'(lim - 1)));
      run_txn(w, s, 8'($urandom), 8'($urandom), wt, kk, 8'($urandom),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
